csr_mfile: RTL

CSR_MFILE -- requirements
Module: csr_mfile

---
 rtl/csr_mfile.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/csr_mfile.sv
// Machine-mode CSR file: combinational reads, write/set/clear updates, trap and
// mret sequencing, 64-bit cycle/instret counters and a registered interrupt request.
module csr_mfile #(
  parameter int XLEN     = 32,
  parameter int MHARTID  = 0,
  parameter int VECTORED = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     raddr,
  output logic [XLEN-1:0] rdata,
  output logic            rillegal,
  input  logic            wvalid,
  input  logic [11:0]     waddr,
  input  logic [1:0]      wop,
  input  logic [XLEN-1:0] wdata,
  output logic            willegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            retire,
  input  logic            irq_msip,
  input  logic            irq_mtip,
  input  logic            irq_meip,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            irq_req,
  output logic [XLEN-1:0] irq_cause
);

  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  localparam logic [XLEN-1:0] ALIGN4 = ~XLEN'(3);

  logic            mst_mie, mst_mpie;
  logic [2:0]      ie_bits;
  logic [XLEN-3:0] tvec_base;
  logic            tvec_mode;
  logic [XLEN-1:0] mscratch, mepc, mcause, mtval;
  logic [63:0]     mcycle, minstret;

  logic [XLEN-1:0] mip_live, old_val, new_val, tvec_addr, trap_target;
  logic [63:0]     mcycle_next, minstret_next;
  logic [2:0]      pend;
  logic [3:0]      irq_code;
  logic            csr_we;

  function automatic logic csr_exists(input logic [11:0] a);
    case (a)
      A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID, A_MSTATUS, A_MISA, A_MIE,
      A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL, A_MIP, A_MCYCLE,
      A_MINSTRET, A_CYCLE, A_INSTRET: csr_exists = 1'b1;
      A_MCYCLEH, A_MINSTRETH, A_CYCLEH, A_INSTRETH: csr_exists = (XLEN == 32);
      default: csr_exists = 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] csr_value(input logic [11:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    case (a)
      A_MHARTID:  v = XLEN'(MHARTID);
      A_MSTATUS:  begin v[3] = mst_mie; v[7] = mst_mpie; v[12:11] = 2'b11; end
      A_MISA:     begin v[XLEN-1:XLEN-2] = (XLEN == 32) ? 2'b01 : 2'b10; v[8] = 1'b1; end
      A_MIE:      begin v[3] = ie_bits[0]; v[7] = ie_bits[1]; v[11] = ie_bits[2]; end
      A_MTVEC:    v = {tvec_base, 1'b0, tvec_mode};
      A_MSCRATCH: v = mscratch;
      A_MEPC:     v = mepc;
      A_MCAUSE:   v = mcause;
      A_MTVAL:    v = mtval;
      A_MIP:      v = mip_live;
      A_MCYCLE, A_CYCLE:       v = mcycle[XLEN-1:0];
      A_MINSTRET, A_INSTRET:   v = minstret[XLEN-1:0];
      A_MCYCLEH, A_CYCLEH:     if (XLEN == 32) v = XLEN'(mcycle[63:32]);
      A_MINSTRETH, A_INSTRETH: if (XLEN == 32) v = XLEN'(minstret[63:32]);
      default:    v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    mip_live     = '0;
    mip_live[3]  = irq_msip;
    mip_live[7]  = irq_mtip;
    mip_live[11] = irq_meip;
  end

  assign rdata    = csr_value(raddr);
  assign rillegal = !csr_exists(raddr);
  assign willegal = wvalid && (waddr[11:10] == 2'b11 || !csr_exists(waddr) || wop == 2'b00);
  // Traps and mret win over a same-cycle CSR write; the write is silently dropped.
  assign csr_we   = wvalid && !willegal && !trap_valid && !mret_valid;
  assign old_val  = csr_value(waddr);

  always_comb begin
    case (wop)
      2'b10:   new_val = old_val | wdata;
      2'b11:   new_val = old_val & ~wdata;
      default: new_val = wdata;
    endcase
  end

  assign tvec_addr   = {tvec_base, 2'b00};
  assign trap_target = (tvec_mode && trap_cause[XLEN-1]) ?
                       tvec_addr + {trap_cause[XLEN-3:0], 2'b00} : tvec_addr;

  assign pend = ie_bits & {irq_meip, irq_mtip, irq_msip};

  always_comb begin
    irq_code = 4'd7;
    if (pend[2])      irq_code = 4'd11;
    else if (pend[0]) irq_code = 4'd3;
  end

  // A write to one counter half replaces its increment and freezes the other half.
  always_comb begin
    mcycle_next   = mcycle + 64'd1;
    minstret_next = minstret + {63'd0, retire};
    if (csr_we) begin
      case (waddr)
        A_MCYCLE:    mcycle_next   = (XLEN == 32) ? {mcycle[63:32], new_val[31:0]} : 64'(new_val);
        A_MINSTRET:  minstret_next = (XLEN == 32) ? {minstret[63:32], new_val[31:0]} : 64'(new_val);
        A_MCYCLEH:   if (XLEN == 32) mcycle_next = {new_val[31:0], mcycle[31:0]};
        A_MINSTRETH: if (XLEN == 32) minstret_next = {new_val[31:0], minstret[31:0]};
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie        <= 1'b0;
      mst_mpie       <= 1'b0;
      ie_bits        <= '0;
      tvec_base      <= '0;
      tvec_mode      <= 1'b0;
      mscratch       <= '0;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      mcycle         <= '0;
      minstret       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      irq_req        <= 1'b0;
      irq_cause      <= '0;
    end else begin
      mcycle         <= mcycle_next;
      minstret       <= minstret_next;
      irq_req        <= mst_mie && (|pend);
      irq_cause      <= (mst_mie && (|pend)) ? {1'b1, {(XLEN-5){1'b0}}, irq_code} : '0;
      redirect_valid <= trap_valid || mret_valid;
      if (trap_valid) begin
        mepc        <= trap_pc & ALIGN4;
        mcause      <= trap_cause;
        mtval       <= trap_tval;
        mst_mpie    <= mst_mie;
        mst_mie     <= 1'b0;
        redirect_pc <= trap_target;
      end else if (mret_valid) begin
        mst_mie     <= mst_mpie;
        mst_mpie    <= 1'b1;
        redirect_pc <= mepc;
      end else if (csr_we) begin
        case (waddr)
          A_MSTATUS: begin
            mst_mie  <= new_val[3];
            mst_mpie <= new_val[7];
          end
          A_MIE:      ie_bits <= {new_val[11], new_val[7], new_val[3]};
          A_MTVEC: begin
            tvec_base <= new_val[XLEN-1:2];
            if (new_val[1:0] == 2'b00)      tvec_mode <= 1'b0;
            else if (new_val[1:0] == 2'b01) tvec_mode <= (VECTORED != 0);
          end
          A_MSCRATCH: mscratch <= new_val;
          A_MEPC:     mepc     <= new_val & ALIGN4;
          A_MCAUSE:   mcause   <= new_val;
          A_MTVAL:    mtval    <= new_val;
          default:    ;
        endcase
      end
    end
  end

endmodule
